// File: rtl/ccd_phase_checker.sv
// CCD clock-phase monitor: synchronises phi_l1/l2/r/p, measures each phi_l2 period
// and checks it against exp_period, reporting lock, sticky errors and measurements.
module ccd_phase_checker #(
   parameter int CNT_W    = 16,
   parameter int TOL      = 2,
   parameter int LOCK_CNT = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_enable,
   input  logic             i_clr_err,
   input  logic [CNT_W-1:0] i_exp_period,
   input  logic             i_phi_l1,
   input  logic             i_phi_l2,
   input  logic             i_phi_r,
   input  logic             i_phi_p,
   output logic             o_locked,
   output logic [5:0]       o_err,
   output logic [CNT_W-1:0] o_period_meas,
   output logic [15:0]      o_p_count
);
   localparam int               GW      = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
   localparam logic [GW-1:0]    LOCK_C  = GW'(LOCK_CNT);
   localparam logic [GW-1:0]    LOCK_M1 = GW'(LOCK_CNT - 1);

   typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, TRACK} state_t;
   state_t r_state, w_state_nx;

   // Synchroniser vectors are ordered {p, r, l2, l1}; l1 is only used as a level.
   logic [3:0]       r_s1, r_s2;
   logic [3:1]       r_s3;
   logic [3:1]       w_rise;
   logic [CNT_W-1:0] r_per, r_l2hi, r_rhi, r_ovl, r_rdly, r_pmeas;
   logic             r_rseen, r_locked;
   logic [GW-1:0]    r_good;
   logic [5:0]       r_err, w_new_err;
   logic [15:0]      r_pcnt;
   logic [4:0]       w_chk;
   logic             w_run, w_stall, w_stall_hit, w_eval, w_idle;

   function automatic logic [CNT_W-1:0] f_absdiff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic logic [CNT_W-1:0] f_sinc(input logic [CNT_W-1:0] a, input logic inc);
      return (inc && !(&a)) ? a + CNT_W'(1) : a;
   endfunction

   assign w_rise   = r_s2[3:1] & ~r_s3;
   assign w_chk[0] = f_absdiff(r_per, i_exp_period) > TOL_C;
   assign w_chk[1] = f_absdiff(r_l2hi, i_exp_period >> 1) > TOL_C;
   assign w_chk[2] = f_absdiff(r_rhi, i_exp_period >> 2) > TOL_C;
   assign w_chk[3] = r_rdly > TOL_C;
   assign w_chk[4] = r_ovl > TOL_C;
   assign w_run    = (r_state == MEASURE) || (r_state == TRACK);
   // Stall threshold is compared one bit wider so 2*exp_period cannot wrap.
   assign w_stall  = w_run && !w_rise[1] && ({1'b0, r_per} >= {i_exp_period, 1'b0});
   assign w_idle   = (w_state_nx == IDLE);

   always_comb begin
      w_state_nx  = r_state;
      w_new_err   = '0;
      w_eval      = 1'b0;
      w_stall_hit = 1'b0;
      if (!i_enable || (i_exp_period < CNT_W'(4))) begin
         w_state_nx = IDLE;
      end else begin
         case (r_state)
            IDLE:      w_state_nx = WAIT_EDGE;
            WAIT_EDGE: if (w_rise[1]) w_state_nx = MEASURE;
            MEASURE, TRACK: begin
               if (w_rise[1]) begin
                  w_state_nx = TRACK;
                  if (r_state == TRACK) begin
                     w_eval         = 1'b1;
                     w_new_err[4:0] = w_chk;
                  end
               end else if (w_stall) begin
                  w_state_nx   = WAIT_EDGE;
                  w_stall_hit  = 1'b1;
                  w_new_err[5] = 1'b1;
               end
            end
            default:   w_state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_s1     <= '0;
         r_s2     <= '0;
         r_s3     <= '0;
         r_per    <= '0;
         r_l2hi   <= '0;
         r_rhi    <= '0;
         r_ovl    <= '0;
         r_rdly   <= '0;
         r_rseen  <= 1'b0;
         r_good   <= '0;
         r_locked <= 1'b0;
         r_err    <= '0;
         r_pmeas  <= '0;
         r_pcnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_s1    <= {i_phi_p, i_phi_r, i_phi_l2, i_phi_l1};
         r_s2    <= r_s1;
         r_s3    <= r_s2[3:1];
         r_err   <= (i_clr_err ? 6'b0 : r_err) | w_new_err;
         if (w_rise[3]) r_pcnt <= r_pcnt + 16'd1;

         if (w_idle) begin
            r_per   <= '0;
            r_l2hi  <= '0;
            r_rhi   <= '0;
            r_ovl   <= '0;
            r_rdly  <= '0;
            r_rseen <= 1'b0;
         end else if (w_rise[1]) begin
            // The rise cycle itself is the first cycle of the new period.
            r_per   <= CNT_W'(1);
            r_l2hi  <= CNT_W'(1);
            r_rhi   <= CNT_W'(r_s2[2]);
            r_ovl   <= CNT_W'(r_s2[0]);
            r_rdly  <= w_rise[2] ? '0 : CNT_W'(1);
            r_rseen <= w_rise[2];
            if (w_run) r_pmeas <= r_per;
         end else begin
            r_per  <= f_sinc(r_per, 1'b1);
            r_l2hi <= f_sinc(r_l2hi, r_s2[1]);
            r_rhi  <= f_sinc(r_rhi, r_s2[2]);
            r_ovl  <= f_sinc(r_ovl, r_s2[0] & r_s2[1]);
            if (!r_rseen) begin
               if (w_rise[2]) r_rseen <= 1'b1;
               else           r_rdly  <= f_sinc(r_rdly, 1'b1);
            end
         end

         if (w_idle || w_stall_hit || (w_eval && (|w_chk))) begin
            r_good   <= '0;
            r_locked <= 1'b0;
         end else if (w_eval) begin
            if (r_good != LOCK_C) r_good <= r_good + GW'(1);
            r_locked <= (r_good >= LOCK_M1);
         end
      end
   end

   assign o_locked      = r_locked;
   assign o_err         = r_err;
   assign o_period_meas = r_pmeas;
   assign o_p_count     = r_pcnt;
endmodule

// File: doc/ccd_phase_checker.md
Name: ccd_phase_checker

Overview:
- Receive-side monitor for the CCD clock phases phi_l1, phi_l2, phi_r and phi_p.
- Synchronises the phases into the system clock domain and measures period, high times, phi_r alignment and phi_l1/phi_l2 overlap against a programmed expected period.
- Reports lock, sticky error flags and measured values to the SoC control logic.
- Sits between the phase generator outputs and the readout/ADC control, so readout only runs on verified clocks.

Parameters:
- CNT_W, 16: width of all cycle counters and of EXP_PERIOD / period_meas.
- TOL, 2: allowed absolute deviation in clk cycles for every timing check.
- LOCK_CNT, 4: consecutive error-free periods required to assert locked.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  checker enable; low forces IDLE.
- clr_err  input  1  one-cycle pulse; clears err.
- exp_period  input  CNT_W  expected phi_l2 period in clk cycles; must be held stable while enabled.
- phi_l1  input  1  CCD phase, asynchronous.
- phi_l2  input  1  CCD phase, asynchronous; timing reference.
- phi_r  input  1  reset phase, asynchronous.
- phi_p  input  1  single-pulse phase, asynchronous.
- locked  output  1  phases verified.
- err  output  6  sticky flags: [0] period, [1] l2 duty, [2] r duty, [3] r phase, [4] l1/l2 overlap, [5] stall.
- period_meas  output  CNT_W  last measured phi_l2 period.
- p_count  output  16  count of phi_p rising edges, wraps.

Behaviour:
- Reset: locked=0, err=0, period_meas=0, p_count=0. All counters and synchroniser flops cleared. FSM=IDLE.
- Synchronisers:
  - Each phase passes a 2-flop synchroniser, then a delay flop.
  - Edge detect is rise = s2 & ~s3 (fall defined the same way, inverted).
  - Latency from an input transition to an updated output is exactly 3 clk edges.
- FSM states:
  - IDLE: entered when enable=0 or exp_period<4. All counters cleared, locked=0, err held. Go to WAIT_EDGE when enable=1 and exp_period>=4.
  - WAIT_EDGE: wait for a phi_l2 rise, then clear counters and go to MEASURE.
  - MEASURE: on the next phi_l2 rise, load period_meas, run no checks, restart counters, go to TRACK.
  - TRACK: on every phi_l2 rise, evaluate all checks for the period just ended, load period_meas, restart counters.
- Counters, restarted on each phi_l2 rise; all saturate at all-ones:
  - per_cnt: clk cycles elapsed.
  - l2_hi: cycles with phi_l2 high.
  - r_hi: cycles with phi_r high.
  - ovl: cycles with phi_l1 and phi_l2 both high.
  - r_dly: cycles from the phi_l2 rise to the first phi_r rise; saturates if phi_r never rises in the period.
- Checks in TRACK, using absolute differences:
  - Period: |per_cnt - exp_period| > TOL sets err[0].
  - l2 duty: |l2_hi - exp_period>>1| > TOL sets err[1].
  - r duty: |r_hi - exp_period>>2| > TOL sets err[2].
  - r phase: r_dly > TOL sets err[3].
  - Overlap: ovl > TOL sets err[4].
- Lock:
  - good_cnt increments on each error-free checked period.
  - Any failing period clears good_cnt and drops locked the same cycle.
  - locked=1 when good_cnt reaches LOCK_CNT; good_cnt saturates at LOCK_CNT.
- Stall:
  - Applies in MEASURE or TRACK.
  - When per_cnt reaches 2*exp_period (computed in CNT_W+1 bits) with no phi_l2 rise: set err[5], locked=0, clear good_cnt, go to WAIT_EDGE.
- err flags:
  - Bits are sticky; a flag is only set, never cleared, by checks.
  - clr_err clears all bits; if clr_err coincides with a new error, the new error wins (bit ends set).
  - enable=0 does not clear err.
- p_count: increments on each synchronised phi_p rise in any state except reset; wraps from 0xFFFF to 0.
- rst mid-operation: all registers return to their reset values on the next edge.

Test Plan:
- Nominal: exp_period=40, TOL=2, LOCK_CNT=4; phi_l2 period 40 at 50% duty, phi_l1=~phi_l2, phi_r high 10 cycles aligned to the phi_l2 rise -> locked=1 at the 5th phi_l2 rise after the first (+3 cycles), period_meas=40, err=0.
- Period error: after lock, one period of 44 cycles -> err[0]=1, locked=0; after 4 further good periods locked=1 again and err[0] stays 1 until clr_err.
- Overlap: phi_l1 = phi_l2 inverted and delayed 5 cycles -> err[4]=1, locked never asserts. With a 2-cycle delay instead -> err[4]=0.
- phi_r faults: phi_r delayed 4 cycles -> err[3]=1. phi_r high 14 cycles -> err[2]=1. phi_r high 11 cycles with 2-cycle delay -> no error.
- Stall: after lock, hold all phases low -> err[5]=1 and locked=0 exactly 80 cycles after the last phi_l2 rise; FSM relocks when phases resume. clr_err pulse clears err to 0.
- Control and count:
  - 3 phi_p pulses -> p_count=3.
  - enable low mid-TRACK -> locked=0, err held.
  - rst high mid-TRACK -> locked, err, period_meas and p_count all 0 one edge later.
  - exp_period=3 with enable=1 -> FSM stays IDLE.
